ahb_cmd_master: RTL

- AHB bus master (initiator) that drives the master side of the team's AHB bus interface; it is the opposite end of the slave modport.
- Accepts single-word or INCR4 read/write commands from a local command port, then requests the bus, waits for grant and runs pipelined address/data phases.
- Handles HREADY wait states, two-cycle ERROR responses and loss of grant.
- Returns read data beat-by-beat and ends every command with a done/err pulse.

---
 rtl/ahb_cmd_master.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_cmd_master.sv
// AHB bus master: turns local SINGLE/INCR4 read/write commands into pipelined AHB transfers,
// with wait-state, two-cycle ERROR and grant-loss handling.
module ahb_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [4*DATA_W-1:0]   cmd_wdata,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [1:0]            rd_idx,
    output logic                  done,
    output logic                  err,
    output logic                  HBUSREQx,
    output logic                  HLOCKx,
    input  logic                  HGRANTx,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP,
    input  logic [DATA_W-1:0]     HRDATA,
    output logic [1:0]            HTRANS,
    output logic [ADDR_W-1:0]     HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_W-1:0]     HWDATA
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_ADDR      = 3'd2,
        S_LAST_DATA = 3'd3,
        S_ERR       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [1:0]            beat_r;
    logic [ADDR_W-1:0]     base_r;
    logic                  write_r, burst_r, regrant_r, first_r;
    logic [4*DATA_W-1:0]   wdata_r;
    logic                  dp_valid_r;
    logic [1:0]            dp_idx_r;
    logic [DATA_W-1:0]     hwdata_r, rd_data_r;
    logic                  rd_valid_r, done_r, err_r;
    logic [1:0]            rd_idx_r;

    logic                  accept_s, addr_acc_s, err_nxt_s, cmd_ready_s;
    logic                  last_beat_s, dp_err_s, rd_fire_s;
    logic [1:0]            htrans_s;
    logic                  hbusreq_s, hwrite_s;
    logic [2:0]            hburst_s;
    logic [ADDR_W-1:0]     haddr_s;

    function automatic logic [DATA_W-1:0] pick_beat(input logic [4*DATA_W-1:0] w, input logic [1:0] b);
        case (b)
            2'd0:    return w[0*DATA_W +: DATA_W];
            2'd1:    return w[1*DATA_W +: DATA_W];
            2'd2:    return w[2*DATA_W +: DATA_W];
            2'd3:    return w[3*DATA_W +: DATA_W];
            default: return {DATA_W{1'b0}};
        endcase
    endfunction

    assign last_beat_s = !burst_r || (beat_r == 2'd3);
    // First ERROR cycle: slave stalls with a non-OKAY response on an outstanding data phase.
    assign dp_err_s    = dp_valid_r && !HREADY && (HRESP != 2'b00);
    assign rd_fire_s   = dp_valid_r && HREADY && (HRESP == 2'b00) && !write_r;

    // Next-state and bus-side address/control decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        addr_acc_s  = 1'b0;
        err_nxt_s   = 1'b0;
        cmd_ready_s = 1'b0;
        htrans_s    = 2'b00;
        hbusreq_s   = 1'b0;
        hwrite_s    = 1'b0;
        hburst_s    = 3'b000;
        haddr_s     = {ADDR_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    if (cmd_burst && (cmd_addr[9:2] > 8'hFC)) begin
                        state_nxt_s = S_DONE;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (dp_err_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    hbusreq_s = 1'b1;
                    if (HGRANTx && HREADY) begin
                        state_nxt_s = S_ADDR;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
            end
            S_ADDR: begin
                if (dp_err_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    hbusreq_s = 1'b1;
                    htrans_s  = first_r ? 2'b10 : 2'b11;
                    haddr_s   = base_r + {{(ADDR_W-4){1'b0}}, beat_r, 2'b00};
                    hwrite_s  = write_r;
                    hburst_s  = !burst_r ? 3'b000 : (regrant_r ? 3'b001 : 3'b011);
                    if (HREADY) begin
                        addr_acc_s = 1'b1;
                        if (last_beat_s) begin
                            state_nxt_s = S_LAST_DATA;
                        end else if (!HGRANTx) begin
                            state_nxt_s = S_REQ;
                        end else begin
                            state_nxt_s = S_ADDR;
                        end
                    end else begin
                        state_nxt_s = S_ADDR;
                    end
                end
            end
            S_LAST_DATA: begin
                if (dp_err_s) begin
                    state_nxt_s = S_ERR;
                end else if (HREADY) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_LAST_DATA;
                end
            end
            S_ERR: begin
                state_nxt_s = S_DONE;
                err_nxt_s   = 1'b1;
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, command latch, beat tracking and registered local-side outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r    <= S_IDLE;
            beat_r     <= 2'd0;
            base_r     <= {ADDR_W{1'b0}};
            write_r    <= 1'b0;
            burst_r    <= 1'b0;
            regrant_r  <= 1'b0;
            first_r    <= 1'b0;
            wdata_r    <= {(4*DATA_W){1'b0}};
            dp_valid_r <= 1'b0;
            dp_idx_r   <= 2'd0;
            hwdata_r   <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_idx_r   <= 2'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            done_r     <= (state_nxt_s == S_DONE);
            err_r      <= err_nxt_s;
            rd_valid_r <= rd_fire_s;
            if (rd_fire_s) begin
                rd_data_r <= HRDATA;
                rd_idx_r  <= dp_idx_r;
            end
            if (accept_s) begin
                base_r    <= cmd_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
                write_r   <= cmd_write;
                burst_r   <= cmd_burst;
                wdata_r   <= cmd_wdata;
                beat_r    <= 2'd0;
                regrant_r <= 1'b0;
                first_r   <= 1'b0;
            end
            if ((state_r == S_REQ) && (state_nxt_s == S_ADDR)) begin
                first_r <= 1'b1;
            end
            // An accepted address opens its data phase, which also retires the previous one.
            if (addr_acc_s) begin
                first_r    <= 1'b0;
                dp_valid_r <= 1'b1;
                dp_idx_r   <= beat_r;
                hwdata_r   <= pick_beat(wdata_r, beat_r);
                if (!last_beat_s) begin
                    beat_r <= beat_r + 2'd1;
                    if (!HGRANTx) begin
                        regrant_r <= 1'b1;
                    end
                end
            end else if ((dp_valid_r && HREADY) || dp_err_s) begin
                dp_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_ready = cmd_ready_s && !HRESET;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_idx    = rd_idx_r;
    assign done      = done_r;
    assign err       = err_r;
    assign HBUSREQx  = hbusreq_s;
    assign HLOCKx    = 1'b0;
    assign HTRANS    = htrans_s;
    assign HADDR     = haddr_s;
    assign HWRITE    = hwrite_s;
    assign HSIZE     = 3'b010;
    assign HBURST    = hburst_s;
    assign HPROT     = 4'b0011;
    assign HWDATA    = hwdata_r;

endmodule
